// File: rtl/ysyx_23060208_axi_arbiter.sv
// Round-robin AXI4 arbiter: IFU and LSU share one SoC master port; LSU reads in the
// CLINT window go to the CLINT slave and LSU writes to that window get a local SLVERR.
module ysyx_23060208_axi_arbiter #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [ADDR_WIDTH-1:0] CLINT_LAST = 32'h0200_ffff
) (
    input  logic                      clock,
    input  logic                      reset,
    // IFU read slave
    input  logic                      ifu_arvalid,
    input  logic [ADDR_WIDTH-1:0]     ifu_araddr,
    input  logic [3:0]                ifu_arid,
    input  logic [7:0]                ifu_arlen,
    input  logic [2:0]                ifu_arsize,
    input  logic [1:0]                ifu_arburst,
    output logic                      ifu_arready,
    input  logic                      ifu_rready,
    output logic                      ifu_rvalid,
    output logic [1:0]                ifu_rresp,
    output logic [2*DATA_WIDTH-1:0]   ifu_rdata,
    output logic                      ifu_rlast,
    output logic [3:0]                ifu_rid,
    // LSU read slave
    input  logic                      lsu_arvalid,
    input  logic [ADDR_WIDTH-1:0]     lsu_araddr,
    input  logic [3:0]                lsu_arid,
    input  logic [7:0]                lsu_arlen,
    input  logic [2:0]                lsu_arsize,
    input  logic [1:0]                lsu_arburst,
    output logic                      lsu_arready,
    input  logic                      lsu_rready,
    output logic                      lsu_rvalid,
    output logic [1:0]                lsu_rresp,
    output logic [2*DATA_WIDTH-1:0]   lsu_rdata,
    output logic                      lsu_rlast,
    output logic [3:0]                lsu_rid,
    // LSU write slave
    input  logic                      lsu_awvalid,
    input  logic [ADDR_WIDTH-1:0]     lsu_awaddr,
    input  logic [3:0]                lsu_awid,
    input  logic [7:0]                lsu_awlen,
    input  logic [2:0]                lsu_awsize,
    input  logic [1:0]                lsu_awburst,
    output logic                      lsu_awready,
    input  logic                      lsu_wvalid,
    input  logic [2*DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [7:0]                lsu_wstrb,
    input  logic                      lsu_wlast,
    output logic                      lsu_wready,
    input  logic                      lsu_bready,
    output logic                      lsu_bvalid,
    output logic [1:0]                lsu_bresp,
    output logic [3:0]                lsu_bid,
    // CLINT read master
    output logic                      clint_arvalid,
    output logic [ADDR_WIDTH-1:0]     clint_araddr,
    output logic [3:0]                clint_arid,
    output logic [7:0]                clint_arlen,
    output logic [2:0]                clint_arsize,
    output logic [1:0]                clint_arburst,
    input  logic                      clint_arready,
    output logic                      clint_rready,
    input  logic                      clint_rvalid,
    input  logic [1:0]                clint_rresp,
    input  logic [2*DATA_WIDTH-1:0]   clint_rdata,
    input  logic                      clint_rlast,
    input  logic [3:0]                clint_rid,
    // SoC master
    output logic                      io_master_awvalid,
    output logic [ADDR_WIDTH-1:0]     io_master_awaddr,
    output logic [3:0]                io_master_awid,
    output logic [7:0]                io_master_awlen,
    output logic [2:0]                io_master_awsize,
    output logic [1:0]                io_master_awburst,
    input  logic                      io_master_awready,
    output logic                      io_master_wvalid,
    output logic [2*DATA_WIDTH-1:0]   io_master_wdata,
    output logic [7:0]                io_master_wstrb,
    output logic                      io_master_wlast,
    input  logic                      io_master_wready,
    output logic                      io_master_bready,
    input  logic                      io_master_bvalid,
    input  logic [1:0]                io_master_bresp,
    input  logic [3:0]                io_master_bid,
    output logic                      io_master_arvalid,
    output logic [ADDR_WIDTH-1:0]     io_master_araddr,
    output logic [3:0]                io_master_arid,
    output logic [7:0]                io_master_arlen,
    output logic [2:0]                io_master_arsize,
    output logic [1:0]                io_master_arburst,
    input  logic                      io_master_arready,
    output logic                      io_master_rready,
    input  logic                      io_master_rvalid,
    input  logic [1:0]                io_master_rresp,
    input  logic [2*DATA_WIDTH-1:0]   io_master_rdata,
    input  logic                      io_master_rlast,
    input  logic [3:0]                io_master_rid
);

    typedef enum logic [3:0] {
        S_IDLE, S_IFU_AR, S_IFU_R, S_LSU_AR, S_LSU_R,
        S_CLINT_AR, S_CLINT_R, S_LSU_WR, S_LSU_B, S_WERR
    } state_e;

    state_e     state_q, state_d;
    logic       last_lsu_q, last_lsu_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [3:0] werr_id_q, werr_id_d;

    logic ifu_req, lsu_req, ar_in_clint, aw_in_clint;
    logic aw_fire, w_fire;

    assign ifu_req     = ifu_arvalid;
    assign lsu_req     = lsu_arvalid | lsu_awvalid;
    assign ar_in_clint = (lsu_araddr >= CLINT_BASE) && (lsu_araddr <= CLINT_LAST);
    assign aw_in_clint = (lsu_awaddr >= CLINT_BASE) && (lsu_awaddr <= CLINT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            last_lsu_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            werr_id_q  <= 4'h0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            werr_id_q  <= werr_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        werr_id_d  = werr_id_q;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;

        ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rresp = '0;
        ifu_rdata   = '0;   ifu_rlast  = 1'b0; ifu_rid   = '0;
        lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rresp = '0;
        lsu_rdata   = '0;   lsu_rlast  = 1'b0; lsu_rid   = '0;
        lsu_awready = 1'b0; lsu_wready = 1'b0;
        lsu_bvalid  = 1'b0; lsu_bresp  = '0;   lsu_bid   = '0;
        clint_arvalid = 1'b0; clint_araddr = '0; clint_arid   = '0;
        clint_arlen   = '0;   clint_arsize = '0; clint_arburst = '0;
        clint_rready  = 1'b0;
        io_master_awvalid = 1'b0; io_master_awaddr = '0; io_master_awid    = '0;
        io_master_awlen   = '0;   io_master_awsize = '0; io_master_awburst = '0;
        io_master_wvalid  = 1'b0; io_master_wdata  = '0; io_master_wstrb   = '0;
        io_master_wlast   = 1'b0; io_master_bready = 1'b0;
        io_master_arvalid = 1'b0; io_master_araddr = '0; io_master_arid    = '0;
        io_master_arlen   = '0;   io_master_arsize = '0; io_master_arburst = '0;
        io_master_rready  = 1'b0;

        case (state_q)
            // Round-robin grant: on a tie the source not granted last time wins
            S_IDLE: begin
                if (ifu_req && (!lsu_req || last_lsu_q)) begin
                    state_d    = S_IFU_AR;
                    last_lsu_d = 1'b0;
                end else if (lsu_req) begin
                    last_lsu_d = 1'b1;
                    if (lsu_arvalid) state_d = ar_in_clint ? S_CLINT_AR : S_LSU_AR;
                    else             state_d = aw_in_clint ? S_WERR : S_LSU_WR;
                end
            end
            S_IFU_AR: begin
                io_master_arvalid = ifu_arvalid;  io_master_araddr  = ifu_araddr;
                io_master_arid    = ifu_arid;     io_master_arlen   = ifu_arlen;
                io_master_arsize  = ifu_arsize;   io_master_arburst = ifu_arburst;
                ifu_arready       = io_master_arready;
                if (ifu_arvalid && io_master_arready) state_d = S_IFU_R;
            end
            S_IFU_R: begin
                ifu_rvalid = io_master_rvalid; ifu_rresp = io_master_rresp;
                ifu_rdata  = io_master_rdata;  ifu_rlast = io_master_rlast;
                ifu_rid    = io_master_rid;    io_master_rready = ifu_rready;
                if (io_master_rvalid && ifu_rready && io_master_rlast) state_d = S_IDLE;
            end
            S_LSU_AR: begin
                io_master_arvalid = lsu_arvalid;  io_master_araddr  = lsu_araddr;
                io_master_arid    = lsu_arid;     io_master_arlen   = lsu_arlen;
                io_master_arsize  = lsu_arsize;   io_master_arburst = lsu_arburst;
                lsu_arready       = io_master_arready;
                if (lsu_arvalid && io_master_arready) state_d = S_LSU_R;
            end
            S_LSU_R: begin
                lsu_rvalid = io_master_rvalid; lsu_rresp = io_master_rresp;
                lsu_rdata  = io_master_rdata;  lsu_rlast = io_master_rlast;
                lsu_rid    = io_master_rid;    io_master_rready = lsu_rready;
                if (io_master_rvalid && lsu_rready && io_master_rlast) state_d = S_IDLE;
            end
            S_CLINT_AR: begin
                clint_arvalid = lsu_arvalid;  clint_araddr  = lsu_araddr;
                clint_arid    = lsu_arid;     clint_arlen   = lsu_arlen;
                clint_arsize  = lsu_arsize;   clint_arburst = lsu_arburst;
                lsu_arready   = clint_arready;
                if (lsu_arvalid && clint_arready) state_d = S_CLINT_R;
            end
            S_CLINT_R: begin
                lsu_rvalid = clint_rvalid; lsu_rresp = clint_rresp;
                lsu_rdata  = clint_rdata;  lsu_rlast = clint_rlast;
                lsu_rid    = clint_rid;    clint_rready = lsu_rready;
                if (clint_rvalid && lsu_rready && clint_rlast) state_d = S_IDLE;
            end
            // AW and W run independently; a finished channel is masked off
            S_LSU_WR: begin
                io_master_awaddr  = lsu_awaddr;  io_master_awid   = lsu_awid;
                io_master_awlen   = lsu_awlen;   io_master_awsize = lsu_awsize;
                io_master_awburst = lsu_awburst;
                io_master_wdata   = lsu_wdata;   io_master_wstrb  = lsu_wstrb;
                io_master_wlast   = lsu_wlast;
                io_master_awvalid = lsu_awvalid && !aw_done_q;
                io_master_wvalid  = lsu_wvalid && !w_done_q;
                lsu_awready       = io_master_awready && !aw_done_q;
                lsu_wready        = io_master_wready && !w_done_q;
                aw_fire = lsu_awvalid && io_master_awready && !aw_done_q;
                w_fire  = lsu_wvalid && io_master_wready && lsu_wlast && !w_done_q;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d   = S_LSU_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q || aw_fire;
                    w_done_d  = w_done_q || w_fire;
                end
            end
            S_LSU_B: begin
                lsu_bvalid = io_master_bvalid; lsu_bresp = io_master_bresp;
                lsu_bid    = io_master_bid;    io_master_bready = lsu_bready;
                if (io_master_bvalid && lsu_bready) state_d = S_IDLE;
            end
            // Writes into the CLINT window are absorbed here and answered with SLVERR
            S_WERR: begin
                lsu_awready = !aw_done_q;
                lsu_wready  = !w_done_q;
                if (lsu_awvalid && !aw_done_q) begin
                    aw_done_d = 1'b1;
                    werr_id_d = lsu_awid;
                end
                if (lsu_wvalid && lsu_wlast && !w_done_q) w_done_d = 1'b1;
                if (aw_done_q && w_done_q) begin
                    lsu_bvalid = 1'b1;
                    lsu_bresp  = 2'b10;
                    lsu_bid    = werr_id_q;
                    if (lsu_bready) begin
                        state_d   = S_IDLE;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// Directed bench for ysyx_23060208_axi_arbiter: cycle table of handshake/grant
// behaviour plus hand-written payload, error-write and mid-burst reset sequences.
module tb_ysyx_23060208_axi_arbiter;

    logic        clock, reset;
    logic        ifu_arvalid, ifu_arready, ifu_rready, ifu_rvalid, ifu_rlast;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic [63:0] ifu_rdata;
    logic        lsu_arvalid, lsu_arready, lsu_rready, lsu_rvalid, lsu_rlast;
    logic [31:0] lsu_araddr;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic [63:0] lsu_rdata;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
    logic        lsu_bready, lsu_bvalid;
    logic [31:0] lsu_awaddr;
    logic [3:0]  lsu_awid, lsu_bid;
    logic [7:0]  lsu_awlen, lsu_wstrb;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic [63:0] lsu_wdata;
    logic        clint_arvalid, clint_arready, clint_rready, clint_rvalid, clint_rlast;
    logic [31:0] clint_araddr;
    logic [3:0]  clint_arid, clint_rid;
    logic [7:0]  clint_arlen;
    logic [2:0]  clint_arsize;
    logic [1:0]  clint_arburst, clint_rresp;
    logic [63:0] clint_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bready, m_bvalid;
    logic        m_arvalid, m_arready, m_rready, m_rvalid, m_rlast;
    logic [31:0] m_awaddr, m_araddr;
    logic [3:0]  m_awid, m_bid, m_arid, m_rid;
    logic [7:0]  m_awlen, m_wstrb, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_bresp, m_arburst, m_rresp;
    logic [63:0] m_wdata, m_rdata;

    ysyx_23060208_axi_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_arready(ifu_arready), .ifu_rready(ifu_rready), .ifu_rvalid(ifu_rvalid),
        .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_arready(lsu_arready), .lsu_rready(lsu_rready), .lsu_rvalid(lsu_rvalid),
        .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bready(lsu_bready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .clint_arvalid(clint_arvalid), .clint_araddr(clint_araddr), .clint_arid(clint_arid),
        .clint_arlen(clint_arlen), .clint_arsize(clint_arsize), .clint_arburst(clint_arburst),
        .clint_arready(clint_arready), .clint_rready(clint_rready), .clint_rvalid(clint_rvalid),
        .clint_rresp(clint_rresp), .clint_rdata(clint_rdata), .clint_rlast(clint_rlast),
        .clint_rid(clint_rid),
        .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr), .io_master_awid(m_awid),
        .io_master_awlen(m_awlen), .io_master_awsize(m_awsize), .io_master_awburst(m_awburst),
        .io_master_awready(m_awready), .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata),
        .io_master_wstrb(m_wstrb), .io_master_wlast(m_wlast), .io_master_wready(m_wready),
        .io_master_bready(m_bready), .io_master_bvalid(m_bvalid), .io_master_bresp(m_bresp),
        .io_master_bid(m_bid), .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr),
        .io_master_arid(m_arid), .io_master_arlen(m_arlen), .io_master_arsize(m_arsize),
        .io_master_arburst(m_arburst), .io_master_arready(m_arready), .io_master_rready(m_rready),
        .io_master_rvalid(m_rvalid), .io_master_rresp(m_rresp), .io_master_rdata(m_rdata),
        .io_master_rlast(m_rlast), .io_master_rid(m_rid)
    );

    // OR of every DUT output: zero exactly when the arbiter drives nothing
    wire any_out = |{ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata, ifu_rlast, ifu_rid,
                     lsu_arready, lsu_rvalid, lsu_rresp, lsu_rdata, lsu_rlast, lsu_rid,
                     lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp, lsu_bid,
                     clint_arvalid, clint_araddr, clint_arid, clint_arlen, clint_arsize,
                     clint_arburst, clint_rready,
                     m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
                     m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
                     m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready};
    wire io_any = |{m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready};
    wire [11:0] obs = {m_arvalid, clint_arvalid, m_awvalid, m_wvalid,
                       ifu_arready, lsu_arready, lsu_awready, lsu_wready,
                       ifu_rvalid, lsu_rvalid, lsu_bvalid, m_rready};

    // in: ifu_arv lsu_arv | lsu_awv lsu_wv | m_arrdy m_rv | m_awrdy m_wrdy m_bv | c_arrdy c_rv
    typedef struct packed {
        logic [10:0] in;
        logic [31:0] araddr;
        logic [31:0] awaddr;
        logic [11:0] exp;
    } vec_t;

    localparam logic [31:0] A_MEM = 32'h8000_0000;
    localparam logic [31:0] A_WR  = 32'h8000_0100;
    localparam logic [31:0] A_CLW = 32'h0200_0010;
    localparam logic [31:0] A_CLR = 32'h0200_bff8;
    localparam int NVEC = 28;

    vec_t vecs [NVEC];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0;
        ifu_arburst = 0; ifu_rready = 1;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0;
        lsu_arburst = 0; lsu_rready = 1;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 0; lsu_awlen = 0; lsu_awsize = 0;
        lsu_awburst = 0; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 1;
        lsu_bready = 1;
        clint_arready = 0; clint_rvalid = 0; clint_rresp = 0; clint_rdata = 0;
        clint_rlast = 1; clint_rid = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
        m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 1; m_rid = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        ifu_arvalid = v.in[10]; lsu_arvalid = v.in[9]; lsu_awvalid = v.in[8];
        lsu_wvalid  = v.in[7];  m_arready   = v.in[6]; m_rvalid    = v.in[5];
        m_awready   = v.in[4];  m_wready    = v.in[3]; m_bvalid    = v.in[2];
        clint_arready = v.in[1]; clint_rvalid = v.in[0];
        lsu_araddr = v.araddr; lsu_awaddr = v.awaddr;
    endtask

    initial begin : main
        logic aw_take, w_take;
        int   aw_cnt, w_cnt, io_act;

        vecs[0]  = '{11'b11_00_00_000_00, A_MEM, 32'h0, 12'h000}; // tie from reset
        vecs[1]  = '{11'b11_00_10_000_00, A_MEM, 32'h0, 12'h880}; // IFU wins
        vecs[2]  = '{11'b01_00_01_000_00, A_MEM, 32'h0, 12'h009};
        vecs[3]  = '{11'b11_00_00_000_00, A_MEM, 32'h0, 12'h000}; // bubble, tie again
        vecs[4]  = '{11'b11_00_00_000_00, A_MEM, 32'h0, 12'h800}; // LSU wins
        vecs[5]  = '{11'b11_00_10_000_00, A_MEM, 32'h0, 12'h840};
        vecs[6]  = '{11'b10_00_00_000_00, A_MEM, 32'h0, 12'h001};
        vecs[7]  = '{11'b10_00_01_000_00, A_MEM, 32'h0, 12'h005};
        vecs[8]  = '{11'b10_11_00_000_00, A_MEM, A_CLW, 12'h000}; // IFU vs write tie
        vecs[9]  = '{11'b10_11_10_000_00, A_MEM, A_CLW, 12'h880};
        vecs[10] = '{11'b00_11_01_000_00, A_MEM, A_CLW, 12'h009};
        vecs[11] = '{11'b00_11_00_000_00, A_MEM, A_CLW, 12'h000};
        vecs[12] = '{11'b00_10_00_000_00, A_MEM, A_CLW, 12'h030}; // error write
        vecs[13] = '{11'b00_01_00_000_00, A_MEM, A_CLW, 12'h010};
        vecs[14] = '{11'b00_00_00_000_00, A_MEM, A_CLW, 12'h002};
        vecs[15] = '{11'b00_11_00_000_00, A_MEM, A_WR,  12'h000};
        vecs[16] = '{11'b00_11_00_010_00, A_MEM, A_WR,  12'h310}; // W first
        vecs[17] = '{11'b00_11_00_010_00, A_MEM, A_WR,  12'h200}; // W masked once done
        vecs[18] = '{11'b00_10_00_100_00, A_MEM, A_WR,  12'h220};
        vecs[19] = '{11'b00_00_00_000_00, A_MEM, A_WR,  12'h000};
        vecs[20] = '{11'b00_00_00_001_00, A_MEM, A_WR,  12'h002};
        vecs[21] = '{11'b01_00_00_000_00, A_CLR, 32'h0, 12'h000}; // CLINT read
        vecs[22] = '{11'b01_00_10_000_10, A_CLR, 32'h0, 12'h440};
        vecs[23] = '{11'b00_00_01_000_01, A_CLR, 32'h0, 12'h004};
        vecs[24] = '{11'b01_11_00_000_00, A_MEM, A_WR,  12'h000}; // LSU read beats write
        vecs[25] = '{11'b01_11_10_000_00, A_MEM, A_WR,  12'h840};
        vecs[26] = '{11'b00_00_01_000_00, A_MEM, A_WR,  12'h005};
        vecs[27] = '{11'b00_00_00_000_00, A_MEM, A_WR,  12'h000};

        set_idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", 64'(any_out), 64'(0));
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].exp));
            @(posedge clock); #1;
        end

        // IFU read through the SoC port, arready after two wait cycles
        set_idle();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arid = 4'h5;
        ifu_arsize = 3'd3; ifu_arburst = 2'b01;
        #1 chk("s1_idle_no_fwd", 64'(m_arvalid), 64'(0));
        @(posedge clock); #1;
        #1 chk("s1_arvalid", 64'(m_arvalid), 64'(1));
        chk("s1_araddr", 64'(m_araddr), 64'(32'h3000_0000));
        chk("s1_arid", 64'(m_arid), 64'(4'h5));
        @(posedge clock); #1;
        @(posedge clock); #1;
        m_arready = 1;
        #1 chk("s1_arready", 64'(ifu_arready), 64'(1));
        @(posedge clock); #1;
        ifu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 64'h0000_0013_0000_0297; m_rid = 4'h5; m_rlast = 1;
        #1 chk("s1_rvalid", 64'(ifu_rvalid), 64'(1));
        chk("s1_rdata", ifu_rdata, 64'h0000_0013_0000_0297);
        chk("s1_rid", 64'(ifu_rid), 64'(4'h5));
        @(posedge clock); #1;
        m_rvalid = 0;
        #1 chk("s1_back_idle", 64'(any_out), 64'(0));
        @(posedge clock); #1;

        // LSU read into the CLINT window
        set_idle();
        lsu_arvalid = 1; lsu_araddr = A_CLR; lsu_arid = 4'h7;
        @(posedge clock); #1;
        clint_arready = 1; m_arready = 1;
        #1 chk("s2_clint_arvalid", 64'(clint_arvalid), 64'(1));
        chk("s2_clint_araddr", 64'(clint_araddr), 64'(A_CLR));
        chk("s2_io_arvalid", 64'(m_arvalid), 64'(0));
        @(posedge clock); #1;
        lsu_arvalid = 0; clint_arready = 0; m_arready = 0;
        clint_rvalid = 1; clint_rdata = 64'hcafe_f00d_1234_5678; clint_rid = 4'h7;
        #1 chk("s2_rvalid", 64'(lsu_rvalid), 64'(1));
        chk("s2_rdata", lsu_rdata, 64'hcafe_f00d_1234_5678);
        chk("s2_rid", 64'(lsu_rid), 64'(4'h7));
        chk("s2_io_rready", 64'(m_rready), 64'(0));
        @(posedge clock); #1;
        set_idle();
        @(posedge clock); #1;

        // SoC write: wready three cycles ahead of awready
        lsu_awvalid = 1; lsu_awaddr = A_WR; lsu_awid = 4'h2; lsu_awsize = 3'd3;
        lsu_awburst = 2'b01; lsu_wvalid = 1; lsu_wdata = 64'h1122_3344_5566_7788;
        lsu_wstrb = 8'h0f; lsu_wlast = 1;
        @(posedge clock); #1;
        aw_cnt = 0; w_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            m_wready = (k == 0); m_awready = (k == 3); m_bvalid = (k == 5);
            m_bid = 4'h2; m_bresp = 2'b00;
            #1;
            if (k == 0) begin
                chk("s3_awaddr", 64'(m_awaddr), 64'(A_WR));
                chk("s3_wstrb", 64'(m_wstrb), 64'(8'h0f));
                chk("s3_wdata", m_wdata, 64'h1122_3344_5566_7788);
            end
            if (m_awvalid && m_awready) aw_cnt++;
            if (m_wvalid && m_wready) w_cnt++;
            chk($sformatf("s3_bvalid_k%0d", k), 64'(lsu_bvalid), 64'(k == 5));
            if (k == 5) begin
                chk("s3_bresp", 64'(lsu_bresp), 64'(0));
                chk("s3_bid", 64'(lsu_bid), 64'(4'h2));
            end
            aw_take = lsu_awvalid && lsu_awready;
            w_take  = lsu_wvalid && lsu_wready;
            @(posedge clock); #1;
            if (aw_take) lsu_awvalid = 0;
            if (w_take)  lsu_wvalid = 0;
        end
        chk("s3_aw_count", 64'(aw_cnt), 64'(1));
        chk("s3_w_count", 64'(w_cnt), 64'(1));

        // Write into the CLINT window is answered locally with SLVERR
        set_idle();
        lsu_awvalid = 1; lsu_awaddr = 32'h0200_4000; lsu_awid = 4'h3;
        lsu_wvalid = 1; lsu_wlast = 1; m_awready = 1; m_wready = 1;
        io_act = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (io_any) io_act++;
            chk($sformatf("s4_bvalid_k%0d", k), 64'(lsu_bvalid), 64'(k == 2));
            if (k == 2) begin
                chk("s4_bresp", 64'(lsu_bresp), 64'(2'b10));
                chk("s4_bid", 64'(lsu_bid), 64'(4'h3));
            end
            aw_take = lsu_awvalid && lsu_awready;
            w_take  = lsu_wvalid && lsu_wready;
            @(posedge clock); #1;
            if (aw_take) lsu_awvalid = 0;
            if (w_take)  lsu_wvalid = 0;
        end
        chk("s4_io_quiet", 64'(io_act), 64'(0));

        // Reset in beat 2 of a 4-beat IFU burst, then a tie
        set_idle();
        ifu_arvalid = 1; ifu_araddr = A_MEM; ifu_arid = 4'h9; ifu_arlen = 8'd3;
        ifu_arsize = 3'd3; ifu_arburst = 2'b01; lsu_arid = 4'h4;
        @(posedge clock); #1;
        m_arready = 1;
        @(posedge clock); #1;
        ifu_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rlast = 0; m_rdata = 64'h1; m_rid = 4'h9;
        #1 chk("s5_beat1", 64'(ifu_rvalid), 64'(1));
        @(posedge clock); #1;
        m_rdata = 64'h2; reset = 1'b0;
        #1 chk("s5_beat2", 64'(ifu_rvalid), 64'(1));
        @(posedge clock); #1;
        reset = 1'b1; ifu_arvalid = 1; lsu_arvalid = 1; lsu_araddr = A_MEM; m_arready = 1;
        #1 chk("s5_reset_quiet", 64'(any_out), 64'(0));
        @(posedge clock); #1;
        m_rvalid = 0;
        #1 chk("s5_tie_arvalid", 64'(m_arvalid), 64'(1));
        chk("s5_tie_arid", 64'(m_arid), 64'(4'h9));
        chk("s5_tie_ifu_ready", 64'(ifu_arready), 64'(1));
        chk("s5_tie_lsu_ready", 64'(lsu_arready), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
